dm_cache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate cache that sits between the processor's memory port and the main-memory model. It accepts one processor request at a time and answers read hits from its local tag/data arrays. Misses and all writes go to main memory over a req/ack handshake. The cache is transparent to the processor: the processor only sees completion pulses.

---
 rtl/dm_cache_ctrl.sv | 156 +++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-through, no-write-allocate cache
// controller. It serves one processor request at a time. Read hits are
// answered from the local tag/data arrays. Read misses and all writes go to
// main memory over a req/ack handshake.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   rwToMem            processor request code (0 idle, 1 read, 2 write, 3 illegal)
//   addrToMem          processor word address
//   dataToMem          processor write data
//   dataFromMem        read data returned to the processor
//   rdEn / wtEn        one-cycle completion pulses for read / write
//   cacheErr           one-cycle pulse on an illegal request code
//   mem_req/mem_we     main-memory request and direction (held until mem_ack)
//   mem_addr/mem_wdata main-memory address and write data
//   mem_rdata/mem_ack  main-memory read data and one-cycle completion
//   hitCnt/missCnt     saturating read hit/miss counters (CACHE_STATS_EN only)
//
// Optional feature: define CACHE_STATS_EN to add the hitCnt/missCnt outputs.
module dm_cache_ctrl #(
  parameter int ADDRWIDTH    = 16,
  parameter int WORDWIDTH    = 16,
  parameter int INDEXWIDTH   = 4,
  parameter int IOSTATEWIDTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IOSTATEWIDTH-1:0] rwToMem,
  input  logic [ADDRWIDTH-1:0]    addrToMem,
  input  logic [WORDWIDTH-1:0]    dataToMem,
  output logic [WORDWIDTH-1:0]    dataFromMem,
  output logic                    rdEn,
  output logic                    wtEn,
  output logic                    cacheErr,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDRWIDTH-1:0]    mem_addr,
  output logic [WORDWIDTH-1:0]    mem_wdata,
  input  logic [WORDWIDTH-1:0]    mem_rdata,
  input  logic                    mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]             hitCnt,
  output logic [15:0]             missCnt
`endif
);

  localparam int TAGWIDTH = ADDRWIDTH - INDEXWIDTH;
  localparam int LINES    = 1 << INDEXWIDTH;

  localparam logic [IOSTATEWIDTH-1:0] REQ_READ    = IOSTATEWIDTH'(1);
  localparam logic [IOSTATEWIDTH-1:0] REQ_WRITE   = IOSTATEWIDTH'(2);
  localparam logic [IOSTATEWIDTH-1:0] REQ_ILLEGAL = IOSTATEWIDTH'(3);

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM, RESP} state_t;

  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAGWIDTH-1:0]   tag_arr  [LINES];
  logic [WORDWIDTH-1:0]  data_arr [LINES];

  logic [INDEXWIDTH-1:0] req_index;
  logic [TAGWIDTH-1:0]   req_tag;
  logic                  req_hit;
  logic [INDEXWIDTH-1:0] fill_index;
  logic [TAGWIDTH-1:0]   fill_tag;
  logic                  turnaround;

  always_comb begin
    req_index  = addrToMem[INDEXWIDTH-1:0];
    req_tag    = addrToMem[ADDRWIDTH-1:INDEXWIDTH];
    req_hit    = valid[req_index] && (tag_arr[req_index] == req_tag);
    // The captured miss address is held in mem_addr, so the fill uses it.
    fill_index = mem_addr[INDEXWIDTH-1:0];
    fill_tag   = mem_addr[ADDRWIDTH-1:INDEXWIDTH];
    // The IDLE turnaround cycle is signalled by the pulse registers
    // themselves: while a completion pulse is high the request is not sampled.
    turnaround = rdEn | wtEn | cacheErr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      valid       <= '0;
      rdEn        <= 1'b0;
      wtEn        <= 1'b0;
      cacheErr    <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      dataFromMem <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
`ifdef CACHE_STATS_EN
      hitCnt      <= '0;
      missCnt     <= '0;
`endif
    end else begin
      rdEn     <= 1'b0;
      wtEn     <= 1'b0;
      cacheErr <= 1'b0;
      case (state)
        IDLE: begin
          if (!turnaround) begin
            if (rwToMem == REQ_READ) begin
              if (req_hit) begin
                dataFromMem <= data_arr[req_index];
                rdEn        <= 1'b1;
`ifdef CACHE_STATS_EN
                if (hitCnt != '1) hitCnt <= hitCnt + 16'd1;
`endif
              end else begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= addrToMem;
                state    <= RD_MISS;
              end
            end else if (rwToMem == REQ_WRITE) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= addrToMem;
              mem_wdata <= dataToMem;
              if (req_hit) data_arr[req_index] <= dataToMem;
              state     <= WR_MEM;
            end else if (rwToMem == REQ_ILLEGAL) begin
              cacheErr <= 1'b1;
            end
          end
        end
        RD_MISS: begin
          if (mem_ack) begin
            data_arr[fill_index] <= mem_rdata;
            tag_arr[fill_index]  <= fill_tag;
            valid[fill_index]    <= 1'b1;
            dataFromMem          <= mem_rdata;
            mem_req              <= 1'b0;
            rdEn                 <= 1'b1;
            state                <= RESP;
`ifdef CACHE_STATS_EN
            if (missCnt != '1) missCnt <= missCnt + 16'd1;
`endif
          end
        end
        WR_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            wtEn    <= 1'b1;
            state   <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: self-checking bench for dm_cache_ctrl. Acts as both the
// processor and the main-memory responder, and predicts every transaction
// from an array-based model of the cache contents and a sparse main memory.
module tb_dm_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rwToMem;
  logic [15:0] addrToMem;
  logic [15:0] dataToMem;
  logic [15:0] dataFromMem;
  logic        rdEn, wtEn, cacheErr;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
`ifdef CACHE_STATS_EN
  logic [15:0] hitCnt, missCnt;
`endif

  dm_cache_ctrl #(
    .ADDRWIDTH(16), .WORDWIDTH(16), .INDEXWIDTH(4), .IOSTATEWIDTH(2)
  ) dut (
    .clk(clk), .reset(reset),
    .rwToMem(rwToMem), .addrToMem(addrToMem), .dataToMem(dataToMem),
    .dataFromMem(dataFromMem), .rdEn(rdEn), .wtEn(wtEn), .cacheErr(cacheErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .hitCnt(hitCnt), .missCnt(missCnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one entry per line plus sparse main memory.
  logic        mv [16];
  logic [11:0] mt [16];
  logic [15:0] md [16];
  logic [15:0] mainmem [int];
  int          exp_hits, exp_misses;

  // Observations from the last transaction.
  int          n_req, cycles;
  logic        req_we, done, got_rd, got_wt, got_err;
  logic [15:0] req_addr, req_wdata, got_data;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mainmem.exists(int'(a))) return mainmem[int'(a)];
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // Drive one request and play main memory with 'lat' extra ack cycles.
  task automatic do_req(input logic [1:0] code, input logic [15:0] a,
                        input logic [15:0] wd, input int lat);
    int   wait_cnt;
    logic pending;
    n_req = 0; done = 1'b0; got_rd = 1'b0; got_wt = 1'b0; got_err = 1'b0;
    pending = 1'b0; wait_cnt = 0; cycles = 0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; got_data = '0;
    rwToMem = code; addrToMem = a; dataToMem = wd;
    for (int c = 1; c <= 64 && !done; c++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      cycles  = c;
      if (rdEn || wtEn || cacheErr) begin
        done = 1'b1; got_rd = rdEn; got_wt = wtEn; got_err = cacheErr;
        got_data = dataFromMem;
      end else if (mem_req) begin
        if (!pending) begin
          n_req++;
          pending = 1'b1; wait_cnt = lat;
          req_we = mem_we; req_addr = mem_addr; req_wdata = mem_wdata;
        end else begin
          chk("mem_stable", {mem_we, mem_addr}, {req_we, req_addr});
        end
        if (wait_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_read(mem_addr);
          pending   = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end
    rwToMem = 2'd0;
    mem_ack = 1'b0;
    chk("done", {63'd0, done}, 64'd1);
    @(posedge clk); #1;
    chk("pulse_clr", {rdEn, wtEn, cacheErr, mem_req}, 64'd0);
  endtask

  task automatic do_read(input logic [15:0] a, input int lat);
    logic [3:0]  idx;
    logic        hit;
    logic [15:0] exp;
    idx = a[3:0];
    hit = mv[idx] && (mt[idx] == a[15:4]);
    exp = hit ? md[idx] : mem_read(a);
    do_req(2'd1, a, 16'h0000, lat);
    chk("rd_pulse", {got_rd, got_wt, got_err}, 64'b100);
    chk("rd_data", got_data, exp);
    chk("rd_nreq", n_req, hit ? 0 : 1);
    chk("rd_lat", cycles, hit ? 1 : 2 + lat);
    if (!hit) begin
      chk("rd_memaddr", {req_we, req_addr}, {1'b0, a});
      mv[idx] = 1'b1; mt[idx] = a[15:4]; md[idx] = exp;
      exp_misses++;
    end else begin
      exp_hits++;
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] wd, input int lat);
    logic [3:0] idx;
    logic       hit;
    idx = a[3:0];
    hit = mv[idx] && (mt[idx] == a[15:4]);
    do_req(2'd2, a, wd, lat);
    chk("wr_pulse", {got_rd, got_wt, got_err}, 64'b010);
    chk("wr_nreq", n_req, 1);
    chk("wr_lat", cycles, 2 + lat);
    chk("wr_mem", {req_we, req_addr, req_wdata}, {1'b1, a, wd});
    mainmem[int'(a)] = wd;
    if (hit) md[idx] = wd;
  endtask

  task automatic do_err(input logic [15:0] a);
    do_req(2'd3, a, 16'hA5A5, 0);
    chk("err_pulse", {got_rd, got_wt, got_err}, 64'b001);
    chk("err_nreq", n_req, 0);
    chk("err_lat", cycles, 1);
  endtask

  initial begin
    logic [15:0] ra, rd;
    int          sel;
    reset = 1'b1; rwToMem = '0; addrToMem = '0; dataToMem = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    model_clear();
    mainmem[int'(16'h0013)] = 16'hBEEF;
    mainmem[int'(16'h0023)] = 16'h5555;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ctl", {rdEn, wtEn, cacheErr, mem_req, mem_we}, 64'd0);
    chk("rst_data", {dataFromMem, mem_addr, mem_wdata}, 64'd0);

    do_read(16'h0013, 3);            // miss, fill BEEF
    do_read(16'h0013, 0);            // hit
    do_write(16'h0013, 16'h1234, 1); // write hit, through to memory
    do_read(16'h0013, 0);            // hit with new data
    do_read(16'h0023, 2);            // alias, replaces line 3
    do_read(16'h0013, 1);            // misses again
    do_write(16'h0040, 16'hCAFE, 0); // miss, no allocate
    do_read(16'h0040, 0);            // must miss
    do_err(16'h0005);
    do_read(16'hFFFF, 1);            // index 15
    do_read(16'hFFFF, 0);
    do_read(16'h0000, 2);            // index 0
    do_read(16'h0000, 0);

    // Stray ack with no outstanding request.
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("stray_ack", {rdEn, wtEn, cacheErr, mem_req}, 64'd0);
    do_read(16'h0000, 0);            // still a hit, state intact

    // Reset while a read miss is outstanding.
    rwToMem = 2'd1; addrToMem = 16'h0077;
    for (int c = 0; c < 10 && !mem_req; c++) begin
      @(posedge clk); #1;
    end
    chk("rst_mreq", {63'd0, mem_req}, 64'd1);
    rwToMem = 2'd0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    chk("midrst_ctl", {rdEn, wtEn, cacheErr, mem_req, mem_we}, 64'd0);
    chk("midrst_data", {dataFromMem, mem_addr, mem_wdata}, 64'd0);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack", {rdEn, wtEn, cacheErr, mem_req, dataFromMem}, 64'd0);
    do_read(16'h0013, 0);            // valid bits were cleared: miss

    // Randomized traffic over a few tags so hits, aliases and writes mix.
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 2);
      ra  = {(sel == 2) ? 12'hFFF : 12'(sel), 4'($urandom_range(0, 15))};
      rd  = 16'($urandom);
      sel = $urandom_range(0, 19);
      if (sel < 10)      do_read(ra, $urandom_range(0, 3));
      else if (sel < 18) do_write(ra, rd, $urandom_range(0, 3));
      else               do_err(ra);
    end

`ifdef CACHE_STATS_EN
    chk("hitcnt", hitCnt, exp_hits);
    chk("misscnt", missCnt, exp_misses);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
